// File: rtl/asicle_pkg.sv
// Shared constants and types for the tile renderer front end: board geometry,
// style codes, and the board entry layout.
package asicle_pkg;

    localparam int TILE    = 76;
    localparam int COLS    = 5;
    localparam int ROWS    = 6;
    localparam int BOARD_N = COLS * ROWS;
    localparam int ADDR_W  = 5;

    localparam logic [4:0] LETTER_BLANK = 5'd31;

    typedef enum logic [2:0] {
        STYLE_WRONG     = 3'd0,
        STYLE_ABSENT    = 3'd1,
        STYLE_MISPLACED = 3'd2,
        STYLE_CORRECT   = 3'd3,
        STYLE_EMPTY     = 3'd4,
        STYLE_ACTIVE    = 3'd5
    } style_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } scan_state_e;

    typedef struct packed {
        style_e     style;
        logic [4:0] letter;
    } tile_t;

endpackage

// File: rtl/board_scan_sync_delay.sv
// Fixed-depth shift register that realigns raw VGA timing with the renderer's
// colour pipeline. Clears to zero on reset.
module sync_delay #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/board_scan.sv
// Raster-to-tile front end: tile-local coordinates, board lookup, timing delay.
// Optional blinking cursor tile enabled by defining BOARD_SCAN_CURSOR_EN.
module board_scan
    import asicle_pkg::*;
#(
    parameter int ORIGIN_X   = 130,
    parameter int ORIGIN_Y   = 12,
    parameter int SYNC_DELAY = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [2:0] wstyle,
    input  logic [4:0] wletter,
`ifdef BOARD_SCAN_CURSOR_EN
    input  logic [4:0] cursor_addr,
    input  logic       cursor_on,
`endif
    output logic       busy,
    output logic [6:0] x,
    output logic [6:0] y,
    output logic [2:0] style,
    output logic [4:0] letter,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       de_out
);

    localparam logic [9:0] LP_OX        = 10'(ORIGIN_X);
    localparam logic [9:0] LP_OY        = 10'(ORIGIN_Y);
    localparam logic [6:0] LP_TILE_LAST = 7'(TILE - 1);
    localparam logic [2:0] LP_COLS      = 3'(COLS);
    localparam logic [2:0] LP_ROWS      = 3'(ROWS);
    localparam logic [4:0] LP_NENT      = 5'(BOARD_N);
    localparam logic [4:0] LP_LAST_ENT  = 5'(BOARD_N - 1);

    scan_state_e r_state, w_state_nxt;
    logic [4:0]  r_clr_idx, w_clr_idx_nxt;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    tile_t       w_wr_data;
    tile_t       r_board [BOARD_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // CLEAR owns the write port; external writes only land in RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_wr_en       = 1'b0;
        w_wr_addr     = waddr;
        w_wr_data     = '{style: style_e'(wstyle), letter: wletter};
        case (r_state)
            ST_CLEAR: begin
                w_wr_en       = 1'b1;
                w_wr_addr     = r_clr_idx;
                w_wr_data     = '{style: STYLE_ABSENT, letter: LETTER_BLANK};
                w_clr_idx_nxt = r_clr_idx + 5'd1;
                if (r_clr_idx == LP_LAST_ENT) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_idx_nxt = '0;
                end
            end
            ST_RUN:  w_wr_en = we && (waddr < LP_NENT);
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    assign busy = (r_state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_board[w_wr_addr] <= w_wr_data;
    end

    logic [6:0] r_lx, r_ly, w_lx_nxt, w_ly_nxt;
    logic [2:0] r_col, r_row, w_col_nxt, w_row_nxt;
    logic       w_inside;
    logic [4:0] w_raddr;
    logic       w_cur_hit;

    // Next counter values are the coordinates of the pixel being sampled now.
    always_comb begin
        w_lx_nxt  = r_lx;
        w_col_nxt = r_col;
        if (hpos == LP_OX) begin
            w_lx_nxt  = '0;
            w_col_nxt = '0;
        end else if (r_lx == LP_TILE_LAST) begin
            w_lx_nxt  = '0;
            w_col_nxt = (r_col == LP_COLS) ? r_col : r_col + 3'd1;
        end else begin
            w_lx_nxt  = r_lx + 7'd1;
        end

        w_ly_nxt  = r_ly;
        w_row_nxt = r_row;
        if (hpos == 10'd0) begin
            if (vpos == LP_OY) begin
                w_ly_nxt  = '0;
                w_row_nxt = '0;
            end else if (r_ly == LP_TILE_LAST) begin
                w_ly_nxt  = '0;
                w_row_nxt = (r_row == LP_ROWS) ? r_row : r_row + 3'd1;
            end else begin
                w_ly_nxt  = r_ly + 7'd1;
            end
        end
    end

    assign w_inside = (hpos >= LP_OX) && (w_col_nxt < LP_COLS) &&
                      (vpos >= LP_OY) && (w_row_nxt < LP_ROWS);
    assign w_raddr  = 5'(w_row_nxt) * 5'(COLS) + 5'(w_col_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lx  <= '0;
            r_col <= '0;
            r_ly  <= '0;
            r_row <= '0;
        end else if (pix_en) begin
            r_lx  <= w_lx_nxt;
            r_col <= w_col_nxt;
            r_ly  <= w_ly_nxt;
            r_row <= w_row_nxt;
        end
    end

`ifdef BOARD_SCAN_CURSOR_EN
    logic [4:0] r_frame;

    always_ff @(posedge clk) begin
        if (rst)
            r_frame <= '0;
        else if (pix_en && hpos == 10'd0 && vpos == 10'd0)
            r_frame <= r_frame + 5'd1;
    end

    assign w_cur_hit = cursor_on && r_frame[4] && (w_raddr == cursor_addr);
`else
    assign w_cur_hit = 1'b0;
`endif

    // Stage p0: geometry and board address captured on the pixel strobe
    logic       r_vld_p0;
    logic       r_inside_p0, r_cur_p0;
    logic [6:0] r_lx_p0, r_ly_p0;
    logic [4:0] r_addr_p0;

    always_ff @(posedge clk) begin
        if (rst) r_vld_p0 <= 1'b0;
        else     r_vld_p0 <= pix_en;
    end

    always_ff @(posedge clk) begin
        if (pix_en) begin
            r_inside_p0 <= w_inside;
            r_cur_p0    <= w_cur_hit;
            r_lx_p0     <= w_lx_nxt;
            r_ly_p0     <= w_ly_nxt;
            r_addr_p0   <= w_inside ? w_raddr : '0;
        end
    end

    // Stage p1: registered board read merged into the output register
    tile_t      w_rd;
    logic [6:0] r_x_p1, r_y_p1;
    style_e     r_style_p1;
    logic [4:0] r_letter_p1;

    assign w_rd = r_board[r_addr_p0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_p1      <= '0;
            r_y_p1      <= '0;
            r_style_p1  <= STYLE_EMPTY;
            r_letter_p1 <= LETTER_BLANK;
        end else if (r_vld_p0) begin
            if (r_inside_p0) begin
                r_x_p1      <= r_lx_p0;
                r_y_p1      <= r_ly_p0;
                r_style_p1  <= r_cur_p0 ? STYLE_ACTIVE : w_rd.style;
                r_letter_p1 <= w_rd.letter;
            end else begin
                r_x_p1      <= '0;
                r_y_p1      <= '0;
                r_style_p1  <= STYLE_EMPTY;
                r_letter_p1 <= LETTER_BLANK;
            end
        end
    end

    assign x      = r_x_p1;
    assign y      = r_y_p1;
    assign style  = r_style_p1;
    assign letter = r_letter_p1;

    logic [2:0] w_sync_dly;

    sync_delay #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk    (clk),
        .rst    (rst),
        .i_data ({hsync_in, vsync_in, de_in}),
        .o_data (w_sync_dly)
    );

    assign {hsync_out, vsync_out, de_out} = w_sync_dly;

endmodule

// File: tb/tb_board_scan.sv
// Randomised bench for board_scan against an arithmetic raster/board model.
module tb_board_scan;

    localparam int OX = 130;
    localparam int OY = 12;
    localparam int T  = 76;
    localparam int NC = 5;
    localparam int NR = 6;
    localparam logic [21:0] BLACK = {7'd0, 7'd0, 3'd4, 5'd31};

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] hpos, vpos;
    logic       hsync_in, vsync_in, de_in;
    logic       we;
    logic [4:0] waddr;
    logic [2:0] wstyle;
    logic [4:0] wletter;
    logic       busy;
    logic [6:0] x, y;
    logic [2:0] style;
    logic [4:0] letter;
    logic       hsync_out, vsync_out, de_out;

    bit cur_on_m;
    int cur_addr_m;

`ifdef BOARD_SCAN_CURSOR_EN
    logic [4:0] cursor_addr;
    logic       cursor_on;
    assign cursor_on   = cur_on_m;
    assign cursor_addr = 5'(cur_addr_m);
`endif

    always #5 clk = ~clk;

    board_scan dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .de_in       (de_in),
        .we          (we),
        .waddr       (waddr),
        .wstyle      (wstyle),
        .wletter     (wletter),
`ifdef BOARD_SCAN_CURSOR_EN
        .cursor_addr (cursor_addr),
        .cursor_on   (cursor_on),
`endif
        .busy        (busy),
        .x           (x),
        .y           (y),
        .style       (style),
        .letter      (letter),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .de_out      (de_out)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: board contents, the visible output word, the pixel
    // waiting for its board lookup, and the frame count.
    logic [7:0]  m_board [30];
    logic [21:0] m_out;
    bit          p_pe, p_ins, p_cur;
    int          p_x, p_y, p_addr;
    int          m_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit pe, input int h, input int v,
                       input bit w, input int a, input int s, input int l);
        bit ins, cur;
        int sx, sy, sa;
        pix_en  = pe;
        hpos    = 10'(h);
        vpos    = 10'(v);
        we      = w;
        waddr   = 5'(a);
        wstyle  = 3'(s);
        wletter = 5'(l);
        ins = pe && h >= OX && h < OX + NC*T && v >= OY && v < OY + NR*T;
        sx  = ins ? (h - OX) % T : 0;
        sy  = ins ? (v - OY) % T : 0;
        sa  = ins ? ((v - OY) / T) * NC + (h - OX) / T : 0;
        cur = ins && cur_on_m && m_frame >= 16 && sa == cur_addr_m;
        if (pe && h == 0 && v == 0) m_frame = (m_frame + 1) % 32;
        tick();
        if (p_pe)
            m_out = p_ins ? {7'(p_x), 7'(p_y), p_cur ? 3'd5 : m_board[p_addr][7:5],
                             m_board[p_addr][4:0]} : BLACK;
        if (w && a < 30) m_board[a] = {3'(s), 5'(l)};
        p_pe   = pe;
        p_ins  = ins;
        p_cur  = cur;
        p_x    = sx;
        p_y    = sy;
        p_addr = sa;
        check($sformatf("pix h=%0d v=%0d", h, v), 32'({x, y, style, letter}), 32'(m_out));
        pix_en = 1'b0;
        we     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 0, 0, 0);
    endtask

    task automatic pix(input int h, input int v);
        cyc(1'b1, h, v, 1'b0, 0, 0, 0);
    endtask

    task automatic write(input int a, input int s, input int l);
        cyc(1'b0, 0, 1, 1'b1, a, s, l);
    endtask

    task automatic frame();
        bit sel [471];
        for (int v = 0; v < 471; v++) sel[v] = (v == 12 || v == 13 || v == 93 ||
                                                v == 300 || v == 467 || v == 468);
        for (int i = 0; i < 3; i++) sel[$urandom_range(0, 470)] = 1'b1;
        for (int v = 0; v < 471; v++) begin
            pix(0, v);
            if (sel[v]) begin
                for (int h = 129; h <= 515; h++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    pix(h, v);
                end
            end
        end
        idle(2);
    endtask

    initial begin
        logic [2:0] q[$];
        logic [2:0] sv;
        int n;
        rst = 1'b1; pix_en = 1'b0; hpos = '0; vpos = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
        we = 1'b0; waddr = '0; wstyle = '0; wletter = '0;
        cur_on_m = 1'b0; cur_addr_m = 0;
        m_out = BLACK; p_pe = 1'b0; m_frame = 0;
        repeat (8) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_out", 32'({x, y, style, letter}), 32'(BLACK));
        check("rst_sync", 32'({hsync_out, vsync_out, de_out}), 32'd0);

        rst = 1'b0;
        repeat (10) tick();
        check("clr_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; waddr = 5'd0; wstyle = 3'd7; wletter = 5'd9;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        we = 1'b0;
        check("busy_len", 32'(n), 32'd30);
        check("clr_out", 32'({x, y, style, letter}), 32'(BLACK));
        for (int i = 0; i < 30; i++) m_board[i] = {3'd1, 5'd31};

        frame();

        write(7, 3, 4);
        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(1, 29));
            if (n != 7) write(n, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
        end

        for (int v = 12; v <= 93; v++) pix(0, v);
        for (int h = 130; h <= 292; h++) pix(h, 93);
        idle(2);
        check("tile7", 32'({x, y, style, letter}), 32'({7'd10, 7'd5, 3'd3, 5'd4}));
        pix(129, 93);
        idle(2);
        check("left_edge", 32'({x, y, style, letter}), 32'(BLACK));
        for (int v = 94; v <= 468; v++) pix(0, v);
        pix(200, 468);
        idle(2);
        check("bottom_edge", 32'({x, y, style, letter}), 32'(BLACK));

        pix(0, 12);
        pix(130, 12);
        write(0, 2, 17);
        check("coll_old", 32'({style, letter}), 32'({3'd1, 5'd31}));
        pix(131, 12);
        idle(2);
        check("coll_new", 32'({x, style, letter}), 32'({7'd1, 3'd2, 5'd17}));

        write(30, 6, 6);
        write(31, 6, 6);
        for (int i = 0; i < 6; i++)
            write(int'($urandom_range(0, 29)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
        frame();

        hsync_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            hsync_in = 1'b0;
            check($sformatf("hs_pulse k=%0d", k), 32'(hsync_out), 32'(k == 6));
        end
        for (int i = 0; i < 5; i++) q.push_back(3'd0);
        for (int k = 1; k <= 40; k++) begin
            sv = 3'($urandom_range(0, 7));
            {hsync_in, vsync_in, de_in} = sv;
            q.push_back(sv);
            tick();
            check("sync_rand", 32'({hsync_out, vsync_out, de_out}), 32'(q[q.size() - 6]));
        end
        {hsync_in, vsync_in, de_in} = 3'd0;

`ifdef BOARD_SCAN_CURSOR_EN
        cur_on_m = 1'b1;
        cur_addr_m = 0;
        for (int f = 0; f < 40; f++) begin
            pix(0, 0);
            pix(0, 12);
            pix(130, 12);
            idle(2);
            check($sformatf("cursor f=%0d", m_frame), 32'(style),
                  32'(m_frame >= 16 ? 3'd5 : m_board[0][7:5]));
        end
        cur_on_m = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
